fetch_queue_unit: RTL and testbench



---
 rtl/fetch_queue_unit.sv | 98 +++++++++
 tb/tb_fetch_queue_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: pipelined instruction fetch with credit-limited issue, in-order response queue and redirect flush
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] out_instr_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_pc_plus4_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
    logic [CW:0]     credit;
    logic [XLEN-1:0] target;
    logic            issue, push, pop, dropping, empty;

    // Handshakes, credit check and head presentation
    always_comb begin
        target         = redirect_pc_i & ~XLEN'(3);
        credit         = {1'b0, count_q} + {1'b0, inflight_q};
        imem_req_o     = ~rst & ~redirect_i & (credit < (CW+1)'(DEPTH));
        imem_addr_o    = fetch_pc_q;
        issue          = imem_req_o & imem_ready_i;
        dropping       = drop_q != '0;
        push           = imem_rvalid_i & ~dropping & ~redirect_i;
        empty          = count_q == '0;
        out_valid_o    = ~empty & ~redirect_i;
        pop            = out_valid_o & ~stall_i;
        out_instr_o    = empty ? '0 : instr_mem_q[head_q];
        out_pc_o       = empty ? '0 : pc_mem_q[head_q];
        out_pc_plus4_o = empty ? '0 : pc_mem_q[head_q] + XLEN'(4);
    end

    // Next state; a redirect overrides issue, push and pop, and every request still
    // outstanding after this cycle's response becomes stale (drop_q is a subset of inflight_q)
    always_comb begin
        fetch_pc_d = redirect_i ? target : issue ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        resp_pc_d  = redirect_i ? target : push ? resp_pc_q + XLEN'(4) : resp_pc_q;
        head_d     = redirect_i ? '0 : pop ? head_q + AW'(1) : head_q;
        tail_d     = redirect_i ? '0 : push ? tail_q + AW'(1) : tail_q;
        count_d    = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
        inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid_i);
        drop_d     = redirect_i ? inflight_q - CW'(imem_rvalid_i)
                                : drop_q - CW'(imem_rvalid_i & dropping);
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Queue storage, written at the tail with the response and its PC
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem_q[tail_q] <= imem_rdata_i;
            pc_mem_q[tail_q]    <= resp_pc_q;
        end
    end

    a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> inflight_q != '0);
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: randomized fetch/redirect/stall stimulus against a scoreboard of expected instructions
module tb_fetch_queue_unit;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ready, imem_rvalid, redirect, stall, out_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_pc_plus4;

    always #5 clk = ~clk;

    fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
        .out_valid_o(out_valid), .out_instr_o(out_instr), .out_pc_o(out_pc),
        .out_pc_plus4_o(out_pc_plus4)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct packed { logic [31:0] addr; int due; } req_t;

    exp_t        sb[$];
    req_t        mq[$];
    int          ret, stale, cyc, checks, errors;
    logic [31:0] model_pc;
    int          p_stall, p_ready, p_rsp, p_redir, p_rst, max_lat;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(2))
            0:       return 32'h100 + 32'($urandom_range(255));
            1:       return 32'hFFFF_FFF0 + 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: checks outputs each cycle and pops the scoreboard when decode consumes the head
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("imem_req_in_reset", 32'(imem_req), 32'd0);
        end else begin
            chk("imem_req", 32'(imem_req), 32'(!redirect && (sb.size() + stale < DEPTH)));
            if (imem_req) chk("imem_addr", imem_addr, model_pc);
            chk("out_valid", 32'(out_valid), 32'(ret > 0 && !redirect));
            if (out_valid && !stall && ret > 0) begin
                e = sb.pop_front();
                ret--;
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
                chk("out_pc_plus4", out_pc_plus4, e.pc + 32'd4);
            end else if (ret == 0) begin
                chk("empty_instr", out_instr, 32'd0);
                chk("empty_pc", out_pc, 32'd0);
                chk("empty_pc_plus4", out_pc_plus4, 32'd0);
            end
        end
    end

    task automatic step(input bit force_rst);
        @(posedge clk);
        #1;
        cyc++;
        rst         = force_rst || ($urandom_range(999) < p_rst);
        stall       = rst || ($urandom_range(99) < p_stall);
        redirect    = !rst && ($urandom_range(99) < p_redir);
        redirect_pc = pick_target();
        imem_ready  = $urandom_range(99) < p_ready;
        if (rst) begin
            imem_rvalid = 1'($urandom_range(1));
            imem_rdata  = $urandom;
        end else if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < p_rsp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        #1;
        if (rst) begin
            sb.delete();
            mq.delete();
            ret      = 0;
            stale    = 0;
            model_pc = RESET_PC;
        end else begin
            if (imem_rvalid) begin
                void'(mq.pop_front());
                if (stale > 0) stale--;
                else ret++;
            end
            if (redirect) begin
                stale   += sb.size() - ret;
                sb.delete();
                ret      = 0;
                model_pc = redirect_pc & ~32'h3;
            end else if (imem_req && imem_ready) begin
                sb.push_back('{pc: model_pc, instr: word_at(model_pc)});
                mq.push_back('{addr: imem_addr, due: cyc + $urandom_range(max_lat, 1)});
                model_pc += 32'd4;
            end
        end
    endtask

    task automatic phase(input int n, input int ps, input int pr, input int prsp,
                         input int pd, input int prst, input int lat);
        p_stall = ps; p_ready = pr; p_rsp = prsp; p_redir = pd; p_rst = prst; max_lat = lat;
        repeat (n) step(1'b0);
    endtask

    initial begin
        stall = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        model_pc = RESET_PC;
        p_stall = 0; p_ready = 0; p_rsp = 100; p_redir = 0; p_rst = 0; max_lat = 1;
        repeat (2) step(1'b1);
        phase(20, 0, 100, 100, 0, 0, 1);
        phase(10, 100, 100, 100, 0, 0, 1);
        phase(10, 0, 100, 100, 0, 0, 1);
        phase(30, 0, 100, 100, 10, 0, 3);
        phase(2000, 30, 70, 80, 8, 0, 3);
        phase(2000, 40, 60, 70, 6, 5, 4);
        phase(500, 5, 100, 100, 3, 0, 1);
        phase(30, 0, 0, 100, 0, 0, 1);
        chk("drain_queue", 32'(sb.size()), 32'd0);
        chk("drain_stale", 32'(stale), 32'd0);
        chk("drain_memory", 32'(mq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
